// File: rtl/imm_decode_stage_pkg.sv
// Shared definitions for the immediate decode stage and the signed immediate extender.
package imm_decode_stage_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  // Extender select: which immediate field, and whether it is a halfword offset.
  typedef enum logic [1:0] {
    EXT_IMM12     = 2'b00,
    EXT_IMM12_SH1 = 2'b01,
    EXT_IMM20     = 2'b10,
    EXT_IMM20_SH1 = 2'b11
  } ext_ctrl_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm12;
    logic [19:0] imm20;
    ext_ctrl_t   ext_ctrl;
    logic        upper;
    logic        illegal;
  } beat_t;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Instruction-in / decoded-beat-out bus of the immediate decode stage.
// valid/ready: a beat transfers on a rising edge where valid && ready; once valid
// is raised the sender holds it and its payload stable until the transfer.
interface imm_decode_stage_if
  import imm_decode_stage_pkg::*;
#(
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [11:0]     out_imm12;
  logic [19:0]     out_imm20;
  ext_ctrl_t       out_ext_ctrl;
  logic            out_upper;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_imm12, out_imm20, out_ext_ctrl, out_upper, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_imm12, out_imm20, out_ext_ctrl, out_upper, out_illegal
  );
endinterface

// File: rtl/imm_decode_stage_imm_field_decode.sv
// Combinational RV32I immediate slicer: picks the immediate bits and extender select.
module imm_field_decode
  import imm_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [11:0] imm12,
  output logic [19:0] imm20,
  output ext_ctrl_t   ext_ctrl,
  output logic        upper,
  output logic        illegal
);

  always_comb begin
    imm12    = '0;
    imm20    = '0;
    ext_ctrl = EXT_IMM12;
    upper    = 1'b0;
    illegal  = 1'b0;
    case (instr[6:0])
      OP_IMM, LOAD, JALR: imm12 = instr[31:20];
      STORE:              imm12 = {instr[31:25], instr[11:7]};
      BRANCH: begin
        imm12    = {instr[31], instr[7], instr[30:25], instr[11:8]};
        ext_ctrl = EXT_IMM12_SH1;
      end
      LUI, AUIPC: begin
        imm20    = instr[31:12];
        ext_ctrl = EXT_IMM20;
        upper    = 1'b1;
      end
      JAL: begin
        imm20    = {instr[31], instr[19:12], instr[20], instr[30:21]};
        ext_ctrl = EXT_IMM20_SH1;
      end
      OP:      ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage with a one-entry skid buffer; in_ready comes
// straight from the skid valid flop so backpressure never forms a combinational path.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int PC_W = 32
) (
  input logic               clk,
  input logic               rst,
  imm_decode_stage_if.slave bus
);

  beat_t           dec;
  beat_t           main_q, skid_q;
  logic [PC_W-1:0] main_pc, skid_pc;
  logic            main_valid, skid_valid;
  logic            accept, deliver;

  imm_field_decode u_decode (
    .instr    (bus.in_instr),
    .imm12    (dec.imm12),
    .imm20    (dec.imm20),
    .ext_ctrl (dec.ext_ctrl),
    .upper    (dec.upper),
    .illegal  (dec.illegal)
  );

  assign dec.opcode = bus.in_instr[6:0];
  assign dec.rd     = bus.in_instr[11:7];
  assign dec.rs1    = bus.in_instr[19:15];
  assign dec.rs2    = bus.in_instr[24:20];

  assign accept  = bus.in_valid && !skid_valid;
  assign deliver = main_valid && bus.out_ready;

  // Skid can only be full while main is full, and accept is blocked while skid is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      main_pc    <= '0;
      skid_pc    <= '0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (deliver) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_pc    <= skid_pc;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q  <= dec;
        main_pc <= bus.in_pc;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_q     <= dec;
        main_pc    <= bus.in_pc;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= dec;
        skid_pc    <= bus.in_pc;
        skid_valid <= 1'b1;
      end
    end
  end

  assign bus.in_ready     = !skid_valid;
  assign bus.out_valid    = main_valid;
  assign bus.out_pc       = main_pc;
  assign bus.out_opcode   = main_q.opcode;
  assign bus.out_rd       = main_q.rd;
  assign bus.out_rs1      = main_q.rs1;
  assign bus.out_rs2      = main_q.rs2;
  assign bus.out_imm12    = main_q.imm12;
  assign bus.out_imm20    = main_q.imm20;
  assign bus.out_ext_ctrl = main_q.ext_ctrl;
  assign bus.out_upper    = main_q.upper;
  assign bus.out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode vectors, skid backpressure, flush, reset.
module tb_imm_decode_stage;
  import imm_decode_stage_pkg::*;

  localparam int PC_W = 32;

  logic clk;
  logic rst;
  int   chk_total;
  int   chk_pass;
  logic [PC_W-1:0] exp_q[$];

  imm_decode_stage_if #(.PC_W(PC_W)) bus ();

  imm_decode_stage #(.PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1 time unit after the rising edge; outputs sampled then.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    idle_in();
    tick();
    tick();
    chk_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); else chk_pass++;
    chk_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); else chk_pass++;
    chk_total++; if (bus.out_pc !== '0) $display("FAIL reset_out_pc: got %h want 0", bus.out_pc); else chk_pass++;
    chk_total++; if (bus.out_imm12 !== 12'h000) $display("FAIL reset_imm12: got %h want 000", bus.out_imm12); else chk_pass++;
    rst = 1'b0;
  endtask

  task automatic test_addi();
    bus.out_ready = 1'b1;
    present(32'hFFF00093, 32'h100);
    tick();
    idle_in();
    chk_total++; if (bus.out_valid !== 1'b1) $display("FAIL addi_valid: got %0b want 1", bus.out_valid); else chk_pass++;
    chk_total++; if (bus.out_imm12 !== 12'hFFF) $display("FAIL addi_imm12: got %h want fff", bus.out_imm12); else chk_pass++;
    chk_total++; if (bus.out_imm20 !== 20'h0) $display("FAIL addi_imm20: got %h want 0", bus.out_imm20); else chk_pass++;
    chk_total++; if (bus.out_ext_ctrl !== 2'b00) $display("FAIL addi_ctrl: got %b want 00", bus.out_ext_ctrl); else chk_pass++;
    chk_total++; if (bus.out_rd !== 5'd1) $display("FAIL addi_rd: got %0d want 1", bus.out_rd); else chk_pass++;
    chk_total++; if (bus.out_illegal !== 1'b0) $display("FAIL addi_illegal: got %0b want 0", bus.out_illegal); else chk_pass++;
    chk_total++; if (bus.out_opcode !== 7'h13) $display("FAIL addi_opcode: got %h want 13", bus.out_opcode); else chk_pass++;
    chk_total++; if (bus.out_pc !== 32'h100) $display("FAIL addi_pc: got %h want 100", bus.out_pc); else chk_pass++;
    tick();
    chk_total++; if (bus.out_valid !== 1'b0) $display("FAIL addi_drained: got %0b want 0", bus.out_valid); else chk_pass++;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    present(32'h00000463, 32'h200);
    tick();
    chk_total++; if (bus.out_imm12 !== 12'h004) $display("FAIL beq_imm12: got %h want 004", bus.out_imm12); else chk_pass++;
    chk_total++; if (bus.out_ext_ctrl !== 2'b01) $display("FAIL beq_ctrl: got %b want 01", bus.out_ext_ctrl); else chk_pass++;
    chk_total++; if (bus.out_pc !== 32'h200) $display("FAIL beq_pc: got %h want 200", bus.out_pc); else chk_pass++;
    present(32'h008000EF, 32'h204);
    tick();
    idle_in();
    chk_total++; if (bus.out_valid !== 1'b1) $display("FAIL jal_no_bubble: got %0b want 1", bus.out_valid); else chk_pass++;
    chk_total++; if (bus.out_imm20 !== 20'h00004) $display("FAIL jal_imm20: got %h want 00004", bus.out_imm20); else chk_pass++;
    chk_total++; if (bus.out_imm12 !== 12'h000) $display("FAIL jal_imm12: got %h want 000", bus.out_imm12); else chk_pass++;
    chk_total++; if (bus.out_ext_ctrl !== 2'b11) $display("FAIL jal_ctrl: got %b want 11", bus.out_ext_ctrl); else chk_pass++;
    chk_total++; if (bus.out_pc !== 32'h204) $display("FAIL jal_pc: got %h want 204", bus.out_pc); else chk_pass++;
    tick();
    chk_total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drained: got %0b want 0", bus.out_valid); else chk_pass++;
  endtask

  task automatic test_stall();
    logic [11:0] exp_imm;
    bus.out_ready = 1'b0;
    exp_q = {};
    present(32'h00100093, 32'h300);  // addi x1,x0,1
    exp_q.push_back(32'h300);
    tick();
    chk_total++; if (bus.in_ready !== 1'b1) $display("FAIL stall_ready_main: got %0b want 1", bus.in_ready); else chk_pass++;
    present(32'h00200113, 32'h304);  // addi x2,x0,2
    exp_q.push_back(32'h304);
    tick();
    chk_total++; if (bus.in_ready !== 1'b0) $display("FAIL stall_ready_skid: got %0b want 0", bus.in_ready); else chk_pass++;
    present(32'h00300193, 32'h308);  // addi x3,x0,3, held until accepted
    exp_q.push_back(32'h308);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_total++; if (bus.out_pc !== 32'h300) $display("FAIL stall_hold_pc: got %h want 300", bus.out_pc); else chk_pass++;
      chk_total++; if (bus.out_imm12 !== 12'h001) $display("FAIL stall_hold_imm: got %h want 001", bus.out_imm12); else chk_pass++;
      chk_total++; if (bus.in_ready !== 1'b0) $display("FAIL stall_hold_ready: got %0b want 0", bus.in_ready); else chk_pass++;
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_total++; if (bus.out_valid !== 1'b1) $display("FAIL order_valid_%0d: got %0b want 1", i, bus.out_valid); else chk_pass++;
      exp_imm = 12'(i + 1);
      chk_total++; if (bus.out_pc !== exp_q[0]) $display("FAIL order_pc_%0d: got %h want %h", i, bus.out_pc, exp_q[0]); else chk_pass++;
      chk_total++; if (bus.out_imm12 !== exp_imm) $display("FAIL order_imm_%0d: got %h want %h", i, bus.out_imm12, exp_imm); else chk_pass++;
      void'(exp_q.pop_front());
      tick();
      if (i == 1) idle_in();
    end
    chk_total++; if (bus.out_valid !== 1'b0) $display("FAIL order_drained: got %0b want 0", bus.out_valid); else chk_pass++;
    chk_total++; if (exp_q.size() !== 0) $display("FAIL order_queue: got %0d want 0", exp_q.size()); else chk_pass++;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    present(32'h00100093, 32'h400);
    tick();
    present(32'h00200113, 32'h404);
    tick();
    chk_total++; if (bus.in_ready !== 1'b0) $display("FAIL flush_prefill: got %0b want 0", bus.in_ready); else chk_pass++;
    present(32'h00300193, 32'h408);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle_in();
    chk_total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", bus.out_valid); else chk_pass++;
    chk_total++; if (bus.in_ready !== 1'b1) $display("FAIL flush_ready: got %0b want 1", bus.in_ready); else chk_pass++;
    // A beat offered with in_ready=1 during flush must also vanish.
    present(32'h00400213, 32'h40C);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle_in();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_no_ghost_%0d: got %0b want 0 (pc %h)", i, bus.out_valid, bus.out_pc); else chk_pass++;
      tick();
    end
  endtask

  task automatic test_lui_illegal();
    bus.out_ready = 1'b1;
    present(32'h123450B7, 32'h500);
    tick();
    chk_total++; if (bus.out_imm20 !== 20'h12345) $display("FAIL lui_imm20: got %h want 12345", bus.out_imm20); else chk_pass++;
    chk_total++; if (bus.out_ext_ctrl !== 2'b10) $display("FAIL lui_ctrl: got %b want 10", bus.out_ext_ctrl); else chk_pass++;
    chk_total++; if (bus.out_upper !== 1'b1) $display("FAIL lui_upper: got %0b want 1", bus.out_upper); else chk_pass++;
    chk_total++; if (bus.out_imm12 !== 12'h000) $display("FAIL lui_imm12: got %h want 000", bus.out_imm12); else chk_pass++;
    present(32'h0000007F, 32'h504);
    tick();
    chk_total++; if (bus.out_valid !== 1'b1) $display("FAIL ill_valid: got %0b want 1", bus.out_valid); else chk_pass++;
    chk_total++; if (bus.out_illegal !== 1'b1) $display("FAIL ill_flag: got %0b want 1", bus.out_illegal); else chk_pass++;
    chk_total++; if (bus.out_imm12 !== 12'h000) $display("FAIL ill_imm12: got %h want 000", bus.out_imm12); else chk_pass++;
    chk_total++; if (bus.out_imm20 !== 20'h0) $display("FAIL ill_imm20: got %h want 0", bus.out_imm20); else chk_pass++;
    chk_total++; if (bus.out_ext_ctrl !== 2'b00) $display("FAIL ill_ctrl: got %b want 00", bus.out_ext_ctrl); else chk_pass++;
    chk_total++; if (bus.out_upper !== 1'b0) $display("FAIL ill_upper: got %0b want 0", bus.out_upper); else chk_pass++;
    chk_total++; if (bus.out_pc !== 32'h504) $display("FAIL ill_pc: got %h want 504", bus.out_pc); else chk_pass++;
    present(32'hFE112E23, 32'h508);  // sw x1,-4(x2)
    tick();
    chk_total++; if (bus.out_imm12 !== 12'hFFC) $display("FAIL sw_imm12: got %h want ffc", bus.out_imm12); else chk_pass++;
    chk_total++; if (bus.out_rs1 !== 5'd2) $display("FAIL sw_rs1: got %0d want 2", bus.out_rs1); else chk_pass++;
    chk_total++; if (bus.out_rs2 !== 5'd1) $display("FAIL sw_rs2: got %0d want 1", bus.out_rs2); else chk_pass++;
    present(32'h002081B3, 32'h50C);  // add x3,x1,x2
    tick();
    idle_in();
    chk_total++; if (bus.out_imm12 !== 12'h000) $display("FAIL add_imm12: got %h want 000", bus.out_imm12); else chk_pass++;
    chk_total++; if (bus.out_illegal !== 1'b0) $display("FAIL add_illegal: got %0b want 0", bus.out_illegal); else chk_pass++;
    chk_total++; if (bus.out_rd !== 5'd3) $display("FAIL add_rd: got %0d want 3", bus.out_rd); else chk_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    present(32'h123450B7, 32'h600);
    tick();
    idle_in();
    chk_total++; if (bus.out_valid !== 1'b1) $display("FAIL rstmid_pre: got %0b want 1", bus.out_valid); else chk_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_total++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", bus.out_valid); else chk_pass++;
    chk_total++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_ready: got %0b want 1", bus.in_ready); else chk_pass++;
    chk_total++; if (bus.out_pc !== '0) $display("FAIL rstmid_pc: got %h want 0", bus.out_pc); else chk_pass++;
    chk_total++; if (bus.out_imm20 !== 20'h0) $display("FAIL rstmid_imm20: got %h want 0", bus.out_imm20); else chk_pass++;
    chk_total++; if (bus.out_upper !== 1'b0) $display("FAIL rstmid_upper: got %0b want 0", bus.out_upper); else chk_pass++;
    chk_total++; if (bus.out_opcode !== 7'h0) $display("FAIL rstmid_opcode: got %h want 0", bus.out_opcode); else chk_pass++;
    chk_total++; if (bus.out_rd !== 5'd0) $display("FAIL rstmid_rd: got %0d want 0", bus.out_rd); else chk_pass++;
  endtask

  initial begin
    chk_total = 0;
    chk_pass  = 0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_flush();
    test_lui_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
